simt_scheduler: RTL and testbench
=================================

# simt_scheduler

Per-core control FSM that sequences one block of threads through fetch, decode, request, wait, execute and update. It generalises the single-PC scheduler in three ways: a parametrised thread count and PC width, a runtime partial-block thread count, and per-thread PCs with min-PC reconvergence for branch divergence. It sits inside each compute core, between the fetcher/decoder/LSUs and the per-thread ALU/PC units. It drives `current_pc` to the fetcher and `active_mask` to the thread lanes.

## Interface
Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes (≥1)
- PC_BITS, 8, program-counter width
- TC_BITS, $clog2(THREADS_PER_BLOCK)+1, width of `thread_count`

Ports (reset: synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch block (sampled in IDLE only)
- thread_count  in  TC_BITS  threads in this block; values above THREADS_PER_BLOCK clamp
- decoded_mem_read_enable  in  1  current instruction reads memory
- decoded_mem_write_enable  in  1  current instruction writes memory
- decoded_ret  in  1  current instruction is RET
- fetcher_state  in  3  fetcher FSM state; 3'b010 = FETCHED
- lsu_state  in  [THREADS_PER_BLOCK][2]  per-lane LSU state; 2'b01 REQUESTING, 2'b10 WAITING
- next_pc  in  [THREADS_PER_BLOCK][PC_BITS]  per-lane computed next PC
- current_pc  out  PC_BITS  PC of the instruction being executed
- active_mask  out  THREADS_PER_BLOCK  lanes executing the current instruction
- core_state  out  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
- diverged  out  1  1 while active_mask ≠ live mask
- done  out  1  block complete

## Operation
- Internal state: `live_mask` (unfinished lanes) and a per-lane `thread_pc[i]` (PC_BITS).
- Reset values: current_pc=0, active_mask=0, core_state=IDLE, diverged=0, done=0, live_mask=0, every thread_pc=0.
- IDLE: when start=1, live_mask and active_mask load the low min(thread_count, THREADS_PER_BLOCK) bits set, thread_pc and current_pc load 0, and the FSM goes to FETCH. If thread_count=0, the FSM goes directly to DONE with done=1.
- FETCH: go to DECODE when fetcher_state==3'b010; otherwise hold.
- DECODE → REQUEST → WAIT: one cycle each, unconditionally.
- WAIT: go to EXECUTE when no lane with active_mask[i]=1 has lsu_state 2'b01 or 2'b10. Inactive lanes are ignored. The FSM spends at least one cycle in WAIT.
- EXECUTE → UPDATE: one cycle.
- UPDATE:
  - Every active lane loads thread_pc[i] ← next_pc[i].
  - If decoded_ret=1, live_mask ← live_mask & ~active_mask.
  - If the new live_mask is 0: done ← 1 and the FSM goes to DONE.
  - Otherwise, m = unsigned minimum of the updated thread_pc over the new live lanes. current_pc ← m, active_mask ← {live lanes with updated thread_pc == m}, and the FSM goes to FETCH.
  - Ties activate all equal lanes, which is how reconvergence happens.
- diverged is registered alongside active_mask: diverged = (new active_mask ≠ new live_mask).
- DONE holds until reset; start is ignored.
- PC values are compared unsigned and are never incremented here, so wrap-around is the PC units' concern. 0 and all-ones PCs are legal.
- decoded_mem_* are informational only; WAIT gating uses lsu_state alone.

## Timing
- Per-instruction latency = fetch cycles + 1 (DECODE) + 1 (REQUEST) + WAIT cycles (≥1) + 1 (EXECUTE) + 1 (UPDATE). With a 1-cycle fetch and no memory, that is 6 cycles.
- current_pc, active_mask and diverged change only on the UPDATE→FETCH edge or on the IDLE→FETCH edge.
- done rises on the same edge core_state becomes DONE.
- Reset asserted in any state returns all outputs to reset values on the next edge. Reset wins over start.

## Configuration
- SIMT_SCHED_DIVERGENCE_EN defined: per-lane PCs and min-PC selection as described above.
- SIMT_SCHED_DIVERGENCE_EN undefined:
  - No thread_pc storage. active_mask always equals live_mask and diverged is tied to 0.
  - UPDATE loads current_pc ← next_pc of the highest-index live lane.
  - decoded_ret clears all of live_mask.
  - thread_count masking still applies.

## Test plan
- thread_count=4, next_pc=pc+1 in all lanes, RET at pc 3 → current_pc 0,1,2,3; active_mask 4'hF throughout; diverged=0; done=1 after UPDATE of pc 3.
- At pc 2, lanes 0–1 take next_pc=5 and lanes 2–3 take next_pc=3, then 3→4→5 → masks 4'b1100 at pc 3 and 4 with diverged=1, then 4'hF at pc 5 with diverged=0.
- thread_count=2 with lsu_state[3]=2'b01 held → active_mask=4'b0011 and WAIT exits after 1 cycle.
- lsu_state[1]=2'b10 for 5 cycles in WAIT → core_state=3'b100 for 5 cycles, then 3'b101.
- Lanes 2–3 RET at pc 3 while lanes 0–1 are at pc 5 → live_mask=4'b0011, done=0; done=1 only after lanes 0–1 RET.
- Reset mid-WAIT → next edge core_state=IDLE, current_pc=0, active_mask=0, done=0. Then start with thread_count=0 → DONE with done=1 one edge later.

Source files
------------

// File: rtl/simt_scheduler.sv
// Per-core SIMT control FSM: runs one thread block through FETCH..UPDATE per instruction.
// Define SIMT_SCHED_DIVERGENCE_EN for per-lane PCs with min-PC reconvergence.
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [TC_BITS-1:0]                          thread_count,
    input  logic                                        decoded_mem_read_enable,
    input  logic                                        decoded_mem_write_enable,
    input  logic                                        decoded_ret,
    input  logic [2:0]                                  fetcher_state,
    input  logic [THREADS_PER_BLOCK-1:0][1:0]           lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]   next_pc,
    output logic [PC_BITS-1:0]                          current_pc,
    output logic [THREADS_PER_BLOCK-1:0]                active_mask,
    output logic [2:0]                                  core_state,
    output logic                                        diverged,
    output logic                                        done
);
    localparam int T = THREADS_PER_BLOCK;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   current_pc_q, current_pc_d;
    logic [T-1:0]         live_mask_q, live_mask_d;
    logic                 done_q, done_d;
    logic [T-1:0]         start_mask, lane_busy, exec_mask, live_after_ret, resume_mask;
    logic [PC_BITS-1:0]   resume_pc;
    logic                 unused_mem_flags;

    // Memory-op decode flags do not gate WAIT; LSU state alone does.
    assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

    // Lanes below the requested count; counts above T saturate naturally.
    always_comb begin
        start_mask = '0;
        lane_busy  = '0;
        for (int i = 0; i < T; i++) begin
            start_mask[i] = (32'(thread_count) > i);
            lane_busy[i]  = (lsu_state[i] == 2'b01) || (lsu_state[i] == 2'b10);
        end
    end

`ifdef SIMT_SCHED_DIVERGENCE_EN
    logic [T-1:0]              active_mask_q, active_mask_d;
    logic                      diverged_q, diverged_d;
    logic [T-1:0][PC_BITS-1:0] thread_pc_q, thread_pc_d, new_pc;

    // Next group to run: the lowest PC among surviving lanes, ties run together.
    always_comb begin
        new_pc      = thread_pc_q;
        resume_pc   = '1;
        resume_mask = '0;
        for (int i = 0; i < T; i++)
            if (active_mask_q[i]) new_pc[i] = next_pc[i];
        for (int i = 0; i < T; i++)
            if (live_after_ret[i] && (new_pc[i] < resume_pc)) resume_pc = new_pc[i];
        for (int i = 0; i < T; i++)
            resume_mask[i] = live_after_ret[i] && (new_pc[i] == resume_pc);
    end

    assign exec_mask      = active_mask_q;
    assign live_after_ret = decoded_ret ? (live_mask_q & ~active_mask_q) : live_mask_q;
`else
    always_comb begin
        resume_pc = current_pc_q;
        for (int i = 0; i < T; i++)
            if (live_mask_q[i]) resume_pc = next_pc[i];
    end

    assign exec_mask      = live_mask_q;
    assign live_after_ret = decoded_ret ? '0 : live_mask_q;
    assign resume_mask    = live_after_ret;
`endif

    always_comb begin
        state_d      = state_q;
        current_pc_d = current_pc_q;
        live_mask_d  = live_mask_q;
        done_d       = done_q;
`ifdef SIMT_SCHED_DIVERGENCE_EN
        active_mask_d = active_mask_q;
        diverged_d    = diverged_q;
        thread_pc_d   = thread_pc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    live_mask_d  = start_mask;
                    current_pc_d = '0;
`ifdef SIMT_SCHED_DIVERGENCE_EN
                    active_mask_d = start_mask;
                    diverged_d    = 1'b0;
                    thread_pc_d   = '0;
`endif
                    if (thread_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH:   if (fetcher_state == 3'b010) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if ((exec_mask & lane_busy) == '0) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                live_mask_d = live_after_ret;
`ifdef SIMT_SCHED_DIVERGENCE_EN
                thread_pc_d = new_pc;
`endif
                if (live_after_ret == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    current_pc_d = resume_pc;
                    state_d      = S_FETCH;
`ifdef SIMT_SCHED_DIVERGENCE_EN
                    active_mask_d = resume_mask;
                    diverged_d    = (resume_mask != live_after_ret);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            current_pc_q <= '0;
            live_mask_q  <= '0;
            done_q       <= 1'b0;
`ifdef SIMT_SCHED_DIVERGENCE_EN
            active_mask_q <= '0;
            diverged_q    <= 1'b0;
            thread_pc_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            current_pc_q <= current_pc_d;
            live_mask_q  <= live_mask_d;
            done_q       <= done_d;
`ifdef SIMT_SCHED_DIVERGENCE_EN
            active_mask_q <= active_mask_d;
            diverged_q    <= diverged_d;
            thread_pc_q   <= thread_pc_d;
`endif
        end
    end

    assign current_pc = current_pc_q;
    assign core_state = state_q;
    assign done       = done_q;
`ifdef SIMT_SCHED_DIVERGENCE_EN
    assign active_mask = active_mask_q;
    assign diverged    = diverged_q;
`else
    assign active_mask = live_mask_q;
    assign diverged    = 1'b0;
`endif
endmodule

// File: tb/tb_simt_scheduler.sv
// Bench for simt_scheduler: phase-level reference model compared every cycle,
// plus directed programs whose FETCH-entry PC/mask sequences are pinned by literals.
module tb_simt_scheduler;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_REQUEST = 3;
    localparam int P_WAIT = 4, P_EXECUTE = 5, P_UPDATE = 6, P_DONE = 7;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [2:0]      thread_count;
    logic            decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret;
    logic [2:0]      fetcher_state;
    logic [3:0][1:0] lsu_state;
    logic [3:0][7:0] next_pc;
    logic [7:0]      current_pc;
    logic [3:0]      active_mask;
    logic [2:0]      core_state;
    logic            diverged, done;

    simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .decoded_mem_read_enable(decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .decoded_ret(decoded_ret), .fetcher_state(fetcher_state),
        .lsu_state(lsu_state), .next_pc(next_pc), .current_pc(current_pc),
        .active_mask(active_mask), .core_state(core_state),
        .diverged(diverged), .done(done)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: what the block should look like after each edge.
    int         m_state;
    logic [7:0] m_pc;
    logic [3:0] m_live, m_active;
    logic       m_div, m_done;
    int         m_tpc[4];

    task automatic model_step();
        int n, best, hi;
        bit busy;
        if (reset) begin
            m_state = P_IDLE; m_pc = 0; m_live = 0; m_active = 0; m_div = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_tpc[i] = 0;
            return;
        end
        case (m_state)
            P_IDLE: if (start) begin
                n = (int'(thread_count) > 4) ? 4 : int'(thread_count);
                m_live = 4'((1 << n) - 1);
                m_active = m_live; m_pc = 0; m_div = 0;
                for (int i = 0; i < 4; i++) m_tpc[i] = 0;
                if (n == 0) begin m_state = P_DONE; m_done = 1; end
                else m_state = P_FETCH;
            end
            P_FETCH:   if (fetcher_state == 3'b010) m_state = P_DECODE;
            P_DECODE:  m_state = P_REQUEST;
            P_REQUEST: m_state = P_WAIT;
            P_WAIT: begin
                busy = 0;
                for (int i = 0; i < 4; i++)
                    if (m_active[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10)) busy = 1;
                if (!busy) m_state = P_EXECUTE;
            end
            P_EXECUTE: m_state = P_UPDATE;
            P_UPDATE: begin
`ifdef SIMT_SCHED_DIVERGENCE_EN
                for (int i = 0; i < 4; i++) if (m_active[i]) m_tpc[i] = int'(next_pc[i]);
                if (decoded_ret) m_live = m_live & ~m_active;
                if (m_live == 0) begin
                    m_done = 1; m_state = P_DONE;
                end else begin
                    best = 256;
                    for (int i = 0; i < 4; i++) if (m_live[i] && m_tpc[i] < best) best = m_tpc[i];
                    m_pc = 8'(best);
                    m_active = 0;
                    for (int i = 0; i < 4; i++) if (m_live[i] && m_tpc[i] == best) m_active[i] = 1;
                    m_div = (m_active != m_live);
                    m_state = P_FETCH;
                end
`else
                hi = 0;
                for (int i = 0; i < 4; i++) if (m_live[i]) hi = i;
                if (decoded_ret) m_live = 0;
                if (m_live == 0) begin
                    m_done = 1; m_state = P_DONE;
                end else begin
                    m_pc = next_pc[hi]; m_state = P_FETCH;
                end
                m_active = m_live; m_div = 0;
`endif
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) model_step();

    // scoreboard: per-cycle compare plus observed FETCH entries and WAIT lengths
    logic [12:0] exp_q[$];
    logic [12:0] ent_q[$];
    int          wait_q[$];
    int          wait_run = 0;
    logic [2:0]  prev_cs = 3'd0;

    always @(negedge clk) if (chk_en) begin
        check("cycle", {core_state, current_pc, active_mask, diverged, done},
              {3'(m_state), m_pc, m_active, m_div, m_done});
        if (core_state == 3'd1 && prev_cs != 3'd1) ent_q.push_back({current_pc, active_mask, diverged});
        if (core_state == 3'd4) wait_run++;
        else begin
            if (prev_cs == 3'd4) wait_q.push_back(wait_run);
            wait_run = 0;
        end
        prev_cs = core_state;
    end

    function automatic logic [12:0] ent(input int pc, input int mask, input bit dv);
        return {8'(pc), 4'(mask), dv};
    endfunction

    task automatic check_entries(input string name);
        check({name, "_count"}, 32'(ent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(name, (i < ent_q.size()) ? 32'(ent_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic check_waits(input string name, input int len, input int cnt);
        check({name, "_count"}, 32'(wait_q.size()), 32'(cnt));
        for (int i = 0; i < wait_q.size(); i++) check(name, 32'(wait_q[i]), 32'(len));
    endtask

    // driver
    int cur_prog = 0, lsu_mode = 0, wait_seen = 0;
    bit fetch_rand = 0;

    task automatic drive_inputs();
        int r;
        if (fetch_rand) begin
            r = $urandom_range(0, 3);
            fetcher_state = (r == 0) ? 3'b010 : (r == 1) ? 3'b000 : (r == 2) ? 3'b011 : 3'b001;
        end else fetcher_state = 3'b010;
        if (m_state == P_WAIT) wait_seen++; else wait_seen = 0;
        for (int i = 0; i < 4; i++) begin
            case (lsu_mode)
                1: lsu_state[i] = (i == 3) ? 2'b01 : 2'b00;
                2: lsu_state[i] = (i == 1 && m_state == P_WAIT && wait_seen < 5) ? 2'b10 : 2'b00;
                3: begin
                    r = $urandom_range(0, 7);
                    lsu_state[i] = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
                end
                default: lsu_state[i] = 2'b00;
            endcase
            case (cur_prog)
                1, 2: next_pc[i] = (m_pc == 8'd2) ? ((i < 2) ? 8'd5 : 8'd3) : m_pc + 8'd1;
                3: begin
                    r = $urandom_range(0, 6);
                    next_pc[i] = (r == 6) ? 8'hFF : 8'(r);
                end
                default: next_pc[i] = m_pc + 8'd1;
            endcase
        end
        case (cur_prog)
            1: decoded_ret = (m_pc == 8'd5);
            2: decoded_ret = (m_pc == 8'd3) || (m_pc == 8'd5);
            3: decoded_ret = ($urandom_range(0, 3) == 0);
            default: decoded_ret = (m_pc == 8'd3);
        endcase
        decoded_mem_read_enable  = 1'($urandom_range(0, 1));
        decoded_mem_write_enable = 1'($urandom_range(0, 1));
    endtask

    task automatic run_block(input int tc, input int prog, input int lmode, input bit frand,
                             input int budget);
        int cyc;
        ent_q.delete(); wait_q.delete();
        cur_prog = prog; lsu_mode = lmode; fetch_rand = frand;
        @(negedge clk); start = 1'b1; thread_count = 3'(tc); drive_inputs();
        @(negedge clk); start = 1'b0; drive_inputs();
        cyc = 0;
        while (m_state != P_DONE && cyc < budget) begin
            @(negedge clk); drive_inputs(); cyc++;
        end
        check("block_done", 32'(done), 32'd1);
        start = 1'b1;
        repeat (2) begin @(negedge clk); drive_inputs(); end
        start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; thread_count = 3'd0; fetcher_state = 3'd0;
        lsu_state = '0; next_pc = '0; decoded_ret = 1'b0;
        decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_state", {15'd0, core_state, current_pc, active_mask, diverged, done}, 32'd0);
        reset = 1'b0;

        // straight-line program, RET at pc 3
        run_block(4, 0, 0, 0, 200);
        exp_q.push_back(ent(0, 4'hF, 0)); exp_q.push_back(ent(1, 4'hF, 0));
        exp_q.push_back(ent(2, 4'hF, 0)); exp_q.push_back(ent(3, 4'hF, 0));
        check_entries("straight");
        check_waits("straight_wait", 1, 4);
        apply_reset();

        // branch at pc 2 splits lanes 0-1 (to 5) from lanes 2-3 (to 3)
        run_block(4, 1, 0, 0, 300);
        exp_q.push_back(ent(0, 4'hF, 0)); exp_q.push_back(ent(1, 4'hF, 0));
        exp_q.push_back(ent(2, 4'hF, 0));
`ifdef SIMT_SCHED_DIVERGENCE_EN
        exp_q.push_back(ent(3, 4'b1100, 1)); exp_q.push_back(ent(4, 4'b1100, 1));
`else
        exp_q.push_back(ent(3, 4'hF, 0)); exp_q.push_back(ent(4, 4'hF, 0));
`endif
        exp_q.push_back(ent(5, 4'hF, 0));
        check_entries("diverge");
        apply_reset();

        // lanes 2-3 RET early while lanes 0-1 wait at pc 5
        run_block(4, 2, 0, 0, 300);
        exp_q.push_back(ent(0, 4'hF, 0)); exp_q.push_back(ent(1, 4'hF, 0));
        exp_q.push_back(ent(2, 4'hF, 0));
`ifdef SIMT_SCHED_DIVERGENCE_EN
        exp_q.push_back(ent(3, 4'b1100, 1)); exp_q.push_back(ent(5, 4'b0011, 0));
`else
        exp_q.push_back(ent(3, 4'hF, 0));
`endif
        check_entries("partial_ret");
        apply_reset();

        // two-thread block, inactive lane 3 stuck REQUESTING
        run_block(2, 0, 1, 0, 200);
        exp_q.push_back(ent(0, 4'b0011, 0)); exp_q.push_back(ent(1, 4'b0011, 0));
        exp_q.push_back(ent(2, 4'b0011, 0)); exp_q.push_back(ent(3, 4'b0011, 0));
        check_entries("tc2");
        check_waits("tc2_wait", 1, 4);
        apply_reset();

        // lane 1 WAITING holds each WAIT for five cycles
        run_block(4, 0, 2, 0, 300);
        check_waits("long_wait", 5, 4);
        apply_reset();

        // thread_count above lane count clamps to all lanes
        run_block(6, 0, 0, 0, 200);
        exp_q.push_back(ent(0, 4'hF, 0)); exp_q.push_back(ent(1, 4'hF, 0));
        exp_q.push_back(ent(2, 4'hF, 0)); exp_q.push_back(ent(3, 4'hF, 0));
        check_entries("clamp");
        apply_reset();

        // reset in the middle of WAIT, then an empty block
        cur_prog = 0; lsu_mode = 2; fetch_rand = 0;
        @(negedge clk); start = 1'b1; thread_count = 3'd4; drive_inputs();
        @(negedge clk); start = 1'b0; drive_inputs();
        cyc = 0;
        while (m_state != P_WAIT && cyc < 50) begin @(negedge clk); drive_inputs(); cyc++; end
        check("reached_wait", 32'(core_state), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(core_state), 32'd0);
        check("rst_pc", 32'(current_pc), 32'd0);
        check("rst_mask", 32'(active_mask), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0; start = 1'b1; thread_count = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("tc0_state", 32'(core_state), 32'd7);
        check("tc0_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        apply_reset();

        // randomized blocks
        for (int b = 0; b < 30; b++) begin
            run_block($urandom_range(0, 7), 3, 3, 1, 3000);
            apply_reset();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
